frame_readback: RTL and testbench

// - Reads a stored frame back out of external RAM (MIG-style command and read FIFOs) and unpacks it into a byte stream for the VGA output path.
// - Mirror of the camera capture/write path:
//   - each 32-bit RAM word holds 4 bytes; byte0 = rd_data[7:0] is output first;
//   - each pixel is 2 bytes.
// - Sits between the RAM read port and the VGA pixel formatter.

---
 rtl/frame_readback.sv | 168 ++++++++++++++++
 tb/tb_frame_readback.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_readback.sv
// Frame readback: issues MIG-style read bursts for one stored frame and unpacks
// each 32-bit word into bytes (byte0 first). Define FRAME_LOOP_EN for continuous refresh.
module frame_readback #(
    parameter int H_RES     = 160,
    parameter int V_RES     = 120,
    parameter int BURST     = 40,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        begin_read,
    output logic        busy,
    output logic        frame_done,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_addr,
    input  logic        cmd_full,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_empty,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int TOTAL_WORDS = H_RES * V_RES / 2;
    localparam int WL_W        = $clog2(TOTAL_WORDS + 1);
    localparam int FIRST_LEN   = (TOTAL_WORDS < BURST) ? TOTAL_WORDS : BURST;
    localparam logic [29:0] STRIDE = 30'(4 * BURST);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [WL_W-1:0] words_left_q, words_left_d;
    logic [6:0]      burst_len_q, burst_len_d;
    logic [6:0]      popped_q, popped_d;
    logic [5:0]      cmd_bl_q, cmd_bl_d;
    logic [29:0]     cmd_addr_q, cmd_addr_d;
    logic [31:0]     hold_q, hold_d;
    logic [1:0]      idx_q, idx_d;
    logic            hold_valid_q, hold_valid_d;

    logic            accept;
    logic            fetch_done;
    logic [6:0]      next_len;

    function automatic logic [6:0] len_of(input logic [WL_W-1:0] left);
        return (32'(left) < 32'(BURST)) ? 7'(left) : 7'(BURST);
    endfunction

    assign cmd_instr  = 3'b001;
    assign cmd_bl     = cmd_bl_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_en     = (state_q == S_ISSUE) && !cmd_full;
    assign frame_done = (state_q == S_DONE);
`ifdef FRAME_LOOP_EN
    assign busy       = (state_q != S_IDLE);
`else
    assign busy       = (state_q == S_ISSUE) || (state_q == S_FETCH);
`endif

    assign out_valid  = hold_valid_q;
    assign out_data   = hold_q[{idx_q, 3'b000} +: 8];
    assign accept     = hold_valid_q && out_ready;

    // A new word is popped only when the hold register is empty or its last
    // byte leaves this cycle, so bytes stream without bubbles across words.
    assign rd_en = (state_q == S_FETCH) && !rd_empty && (popped_q < burst_len_q) &&
                   (!hold_valid_q || (idx_q == 2'd3 && out_ready));

    // The burst is finished only once every popped byte has been consumed.
    assign fetch_done = (state_q == S_FETCH) && (popped_q == burst_len_q) && !hold_valid_q;
    assign next_len   = len_of(words_left_q);

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        burst_len_d  = burst_len_q;
        popped_d     = popped_q;
        cmd_bl_d     = cmd_bl_q;
        cmd_addr_d   = cmd_addr_q;
        hold_d       = hold_q;
        idx_d        = idx_q;
        hold_valid_d = hold_valid_q;

        case (state_q)
            S_IDLE: begin
                if (begin_read) begin
                    state_d      = S_ISSUE;
                    words_left_d = WL_W'(TOTAL_WORDS);
                    burst_len_d  = 7'(FIRST_LEN);
                    cmd_bl_d     = 6'(FIRST_LEN - 1);
                    cmd_addr_d   = 30'(BASE_ADDR);
                end
            end
            S_ISSUE: begin
                // cmd_bl/cmd_addr were set on entry and simply hold while cmd_full.
                if (cmd_en) begin
                    state_d      = S_FETCH;
                    words_left_d = words_left_q - WL_W'(burst_len_q);
                    popped_d     = 7'd0;
                end
            end
            S_FETCH: begin
                if (fetch_done) begin
                    if (words_left_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_ISSUE;
                        burst_len_d = next_len;
                        cmd_bl_d    = 6'(next_len - 7'd1);
                        cmd_addr_d  = cmd_addr_q + STRIDE;
                    end
                end
            end
            default: begin
`ifdef FRAME_LOOP_EN
                state_d      = S_ISSUE;
                words_left_d = WL_W'(TOTAL_WORDS);
                burst_len_d  = 7'(FIRST_LEN);
                cmd_bl_d     = 6'(FIRST_LEN - 1);
                cmd_addr_d   = 30'(BASE_ADDR);
`else
                state_d      = S_IDLE;
`endif
            end
        endcase

        if (rd_en) begin
            hold_d       = rd_data;
            idx_d        = 2'd0;
            hold_valid_d = 1'b1;
            popped_d     = popped_q + 7'd1;
        end else if (accept) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            burst_len_q  <= '0;
            popped_q     <= '0;
            cmd_bl_q     <= '0;
            cmd_addr_q   <= '0;
            hold_q       <= '0;
            idx_q        <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            burst_len_q  <= burst_len_d;
            popped_q     <= popped_d;
            cmd_bl_q     <= cmd_bl_d;
            cmd_addr_q   <= cmd_addr_d;
            hold_q       <= hold_d;
            idx_q        <= idx_d;
            hold_valid_q <= hold_valid_d;
        end
    end

endmodule

// File: tb/tb_frame_readback.sv
// Directed bench for frame_readback on a 10x9 frame (45 words, bursts of 40 and 5).
module tb_frame_readback;

    logic        clk = 1'b0;
    logic        rst;
    logic        begin_read;
    logic        busy, frame_done, cmd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_addr;
    logic        cmd_full;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_empty;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;

    int checks = 0;
    int errors = 0;

    frame_readback #(.H_RES(10), .V_RES(9), .BURST(40), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .begin_read(begin_read), .busy(busy), .frame_done(frame_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_addr(cmd_addr),
        .cmd_full(cmd_full), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // RAM model: word w holds bytes 4w..4w+3, byte0 in the low lane.
    function automatic logic [31:0] mkword(input int w);
        return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    endfunction

    logic [31:0] mem [0:255];
    logic [7:0]  wr_ptr, rd_ptr;
    logic        empty_force = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 8'd0;
            rd_ptr <= 8'd0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + 8'd1;
            if (cmd_en) begin
                for (int i = 0; i < 64; i++)
                    if (i <= int'(cmd_bl)) mem[8'(int'(wr_ptr) + i)] <= mkword(int'(cmd_addr[29:2]) + i);
                wr_ptr <= wr_ptr + 8'(cmd_bl) + 8'd1;
            end
        end
    end
    assign rd_empty = (wr_ptr == rd_ptr) || empty_force;
    assign rd_data  = mem[rd_ptr];

    // Passive logs of accepted bytes, issued commands and frame_done cycles.
    logic [7:0]  byte_log [0:4095];
    logic [29:0] cmd_addr_log [0:63];
    logic [5:0]  cmd_bl_log [0:63];
    int n_bytes = 0, n_cmds = 0, n_done = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                byte_log[n_bytes] <= out_data;
                n_bytes <= n_bytes + 1;
            end
            if (cmd_en) begin
                cmd_addr_log[n_cmds] <= cmd_addr;
                cmd_bl_log[n_cmds]   <= cmd_bl;
                n_cmds <= n_cmds + 1;
            end
            if (frame_done) n_done <= n_done + 1;
        end
    end

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_begin;
        begin_read = 1'b1;
        @(negedge clk);
        begin_read = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_en, rd_en, out_valid, frame_done, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000", {cmd_en, rd_en, out_valid, frame_done, busy});
        end
        checks++;
        if (cmd_bl !== 6'd0 || cmd_addr !== 30'd0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_values got bl=%0d addr=%0d data=%0h want 0 0 0", cmd_bl, cmd_addr, out_data);
        end
        checks++;
        if (cmd_instr !== 3'b001) begin
            errors++;
            $display("FAIL cmd_instr got %b want 001", cmd_instr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame;
        int b0, c0, d0, bad;
        bit ok;
        b0 = n_bytes; c0 = n_cmds; d0 = n_done;
        out_ready = 1'b1;
        pulse_begin();
        checks++;
        if (busy !== 1'b1 || cmd_en !== 1'b1) begin
            errors++;
            $display("FAIL frame_start got busy=%b cmd_en=%b want 1 1", busy, cmd_en);
        end
        wait_done(2000, ok);
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_seen got ok=%b busy=%b want 1 0", ok, busy);
        end
        @(negedge clk);
        checks++;
        if (n_cmds - c0 != 2 || cmd_addr_log[c0] !== 30'd0 || cmd_bl_log[c0] !== 6'd39 ||
            cmd_addr_log[c0+1] !== 30'd160 || cmd_bl_log[c0+1] !== 6'd4) begin
            errors++;
            $display("FAIL frame_cmds got n=%0d a0=%0d bl0=%0d a1=%0d bl1=%0d want 2 0 39 160 4",
                     n_cmds - c0, cmd_addr_log[c0], cmd_bl_log[c0], cmd_addr_log[c0+1], cmd_bl_log[c0+1]);
        end
        bad = 0;
        for (int i = 0; i < 180; i++) if (byte_log[b0+i] !== 8'(i)) bad++;
        checks++;
        if (n_bytes - b0 != 180 || bad != 0) begin
            errors++;
            $display("FAIL frame_bytes got count=%0d bad=%0d want 180 0", n_bytes - b0, bad);
        end
        checks++;
        if (n_done - d0 != 1) begin
            errors++;
            $display("FAIL frame_done_pulses got %0d want 1", n_done - d0);
        end
    endtask

    task automatic test_cmd_full;
        int b0, c0, bad;
        bit ok;
        b0 = n_bytes; c0 = n_cmds; bad = 0;
        out_ready = 1'b1;
        cmd_full  = 1'b1;
        pulse_begin();
        for (int i = 0; i < 5; i++) begin
            if (cmd_en !== 1'b0 || cmd_addr !== 30'd0 || cmd_bl !== 6'd39) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cmd_full_hold got %0d bad cycles want 0", bad);
        end
        cmd_full = 1'b0;
        #1;
        checks++;
        if (cmd_en !== 1'b1 || cmd_addr !== 30'd0 || cmd_bl !== 6'd39) begin
            errors++;
            $display("FAIL cmd_full_release got en=%b addr=%0d bl=%0d want 1 0 39", cmd_en, cmd_addr, cmd_bl);
        end
        wait_done(2000, ok);
        @(negedge clk);
        checks++;
        if (!ok || n_bytes - b0 != 180 || n_cmds - c0 != 2) begin
            errors++;
            $display("FAIL cmd_full_frame got ok=%b bytes=%0d cmds=%0d want 1 180 2", ok, n_bytes - b0, n_cmds - c0);
        end
    endtask

    task automatic test_backpressure;
        int b0, bad, stall_bad, empty_bad;
        bit ok, did_empty, stall;
        logic [7:0] pd;
        b0 = n_bytes; ok = 1'b0; did_empty = 1'b0; stall = 1'b0; stall_bad = 0; empty_bad = 0; pd = 8'd0;
        out_ready = 1'b1;
        pulse_begin();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (stall && (out_valid !== 1'b1 || out_data !== pd)) stall_bad++;
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
            if (!did_empty && n_bytes - b0 == 60) begin
                did_empty   = 1'b1;
                empty_force = 1'b1;
                out_ready   = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (rd_en !== 1'b0) empty_bad++;
                    if (k >= 5 && out_valid !== 1'b0) empty_bad++;
                end
                empty_force = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            stall = out_valid && !out_ready;
            pd    = out_data;
        end
        out_ready = 1'b1;
        checks++;
        if (!ok || !did_empty) begin
            errors++;
            $display("FAIL bp_complete got ok=%b empty_window=%b want 1 1", ok, did_empty);
        end
        checks++;
        if (empty_bad != 0) begin
            errors++;
            $display("FAIL bp_empty_drain got %0d bad samples want 0", empty_bad);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL bp_stall_stable got %0d bad samples want 0", stall_bad);
        end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 180; i++) if (byte_log[b0+i] !== 8'(i)) bad++;
        checks++;
        if (n_bytes - b0 != 180 || bad != 0) begin
            errors++;
            $display("FAIL bp_bytes got count=%0d bad=%0d want 180 0", n_bytes - b0, bad);
        end
    endtask

    task automatic test_reset_mid;
        int b0, bad;
        bit ok, hit;
        b0 = n_bytes; hit = 1'b0;
        out_ready = 1'b1;
        pulse_begin();
        for (int c = 0; c < 500; c++) begin
            if (n_bytes - b0 >= 10) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid_progress got %0d bytes want >=10", n_bytes - b0);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, cmd_en, rd_en} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_state got %b want 0000", {out_valid, busy, cmd_en, rd_en});
        end
        rst = 1'b0;
        @(negedge clk);
        b0 = n_bytes;
        pulse_begin();
        #1;
        checks++;
        if (cmd_en !== 1'b1 || cmd_addr !== 30'd0) begin
            errors++;
            $display("FAIL rst_mid_restart got en=%b addr=%0d want 1 0", cmd_en, cmd_addr);
        end
        wait_done(2000, ok);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 180; i++) if (byte_log[b0+i] !== 8'(i)) bad++;
        checks++;
        if (!ok || n_bytes - b0 != 180 || bad != 0) begin
            errors++;
            $display("FAIL rst_mid_frame got ok=%b count=%0d bad=%0d want 1 180 0", ok, n_bytes - b0, bad);
        end
    endtask

    task automatic test_begin_held;
        int c0, d0, zeros;
        bit ok;
        c0 = n_cmds; d0 = n_done;
        out_ready  = 1'b1;
        begin_read = 1'b1;
        wait_done(2000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL held_first_done got timeout want frame_done");
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_done_cycle_ignored got busy=%b want 0", busy);
        end
        @(negedge clk);
        begin_read = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_restart got busy=%b want 1", busy);
        end
        zeros = 0;
        for (int i = c0; i < n_cmds; i++) if (cmd_addr_log[i] == 30'd0) zeros++;
        checks++;
        if (n_cmds - c0 != 2 || zeros != 1) begin
            errors++;
            $display("FAIL held_cmds got n=%0d addr0=%0d want 2 1", n_cmds - c0, zeros);
        end
        wait_done(2000, ok);
        @(negedge clk);
        checks++;
        if (!ok || n_done - d0 != 2 || n_cmds - c0 != 4) begin
            errors++;
            $display("FAIL held_second got ok=%b done=%0d cmds=%0d want 1 2 4", ok, n_done - d0, n_cmds - c0);
        end
    endtask

    task automatic test_loop;
        int c0, d0;
        bit ok;
        c0 = n_cmds; d0 = n_done;
        out_ready = 1'b1;
        pulse_begin();
        wait_done(2000, ok);
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL loop_done got ok=%b busy=%b want 1 1", ok, busy);
        end
        @(negedge clk);
        checks++;
        if (cmd_en !== 1'b1 || cmd_addr !== 30'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL loop_reissue got en=%b addr=%0d busy=%b want 1 0 1", cmd_en, cmd_addr, busy);
        end
        wait_done(2000, ok);
        @(negedge clk);
        checks++;
        if (!ok || n_done - d0 != 2 || n_cmds - c0 != 4) begin
            errors++;
            $display("FAIL loop_second got ok=%b done=%0d cmds=%0d want 1 2 4", ok, n_done - d0, n_cmds - c0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; begin_read = 1'b0; cmd_full = 1'b0; out_ready = 1'b0;
        test_reset();
`ifdef FRAME_LOOP_EN
        test_loop();
`else
        test_frame();
        test_cmd_full();
        test_backpressure();
        test_reset_mid();
        test_begin_held();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
